seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Downstream of the display-select stage. Consumes the 16-bit, 4-digit BCD word that stage produces and drives a 4-digit multiplexed seven-segment display.
- Time-multiplexes the digits with a refresh counter, applies leading-zero blanking and anti-ghosting dead time, and double-buffers the input so a value never changes mid-frame.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot; must be >= 4.
- DEAD_CYC, 8: cycles at the start of each slot with all anodes off (anti-ghost); must be < REFRESH_DIV.
- ACTIVE_LOW, 1: 1 means seg, dp and an are active-low (common anode); 0 means active-high.

Ports:
- clk  in  1  system clock; the block uses this one clock only.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  1 = scan the display; 0 = display dark and scan frozen.
- bcd_in  in  16  digit3..digit0, with [3:0] as the rightmost digit.
- update  in  1  one-cycle strobe; capture bcd_in into the pending register.
- blank_lz  in  1  1 = blank leading zeros.
- brightness  in  2  duty level; used only with the optional feature.
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp  out  1  decimal point; always inactive.
- an  out  4  anode select; an[0] is the rightmost digit.
- frame_done  out  1  one-cycle pulse when a full 4-digit frame completes.

Behaviour:
- Reset (resetn=0, asynchronous):
  - Refresh counter = 0, digit index = 0.
  - Pending register = 0, active register = 0, pend_valid = 0.
  - seg, dp and an all inactive; frame_done = 0.
- Capture:
  - update=1 at a clock edge loads bcd_in into pending and sets pend_valid.
  - A later update before the frame boundary overwrites pending (last one wins).
  - update is honoured even when enable=0.
- Refresh counter:
  - When enable=1, counts 0..REFRESH_DIV-1 and wraps.
  - On the terminal count, digit index advances 0 -> 1 -> 2 -> 3 -> 0.
- Frame boundary (index wraps 3 -> 0):
  - frame_done = 1 for exactly that cycle.
  - If pend_valid: active <= pending and pend_valid is cleared, in the same cycle.
  - If update coincides with the boundary: the boundary copies the old pending, then the new value lands in pending with pend_valid=1, so it displays one frame later.
- Digit decode, applied to active[4*idx+3 : 4*idx]:
  - 0-9: standard patterns.
  - 0xA: '-' (g only).
  - 0xB: 'E'.
  - 0xC-0xF: blank.
- Leading-zero blanking (blank_lz=1):
  - Digit k (k = 3..1) is blanked if it and every higher digit equal 0.
  - Digit 0 is never blanked, so 0x0000 shows "   0".
- Anode timing:
  - an asserts only the current digit, and only while counter >= DEAD_CYC.
  - During dead time all anodes are off.
  - A blanked digit drives all segments off; its anode still follows the timing above.
- Outputs are registered: seg and an reflect the new index 1 cycle after the index changes.
- enable=0:
  - Counter and index hold; an and seg inactive; frame_done = 0.
  - On re-enable, scanning resumes from the held state.
- Reset in mid-frame: immediate return to the reset state; pending data is lost.
- Polarity: ACTIVE_LOW inverts seg, dp and an at the output stage only; internal logic stays active-high.

Optional Feature:
- Macro: SEG7_SCAN_BRIGHTNESS_EN.
- Defined: the anode on-window within a slot (after dead time) is truncated to (brightness+1)/4 of the remaining slot cycles, floor-rounded, minimum 1 cycle. brightness=3 gives the full window.
- Undefined: the brightness input is ignored and the full window is used.

Test Plan:
- Reset and idle: REFRESH_DIV=8, DEAD_CYC=2, ACTIVE_LOW=1, resetn=0 -> an=4'b1111, seg=7'h7F, frame_done=0; all hold while resetn is low.
- Basic scan: update with bcd_in=16'h1234, enable=1 -> from the next frame, an cycles 1110, 1101, 1011, 0111 showing 4, 3, 2, 1; each anode is low for 6 of 8 cycles; frame_done pulses every 32 cycles.
- Leading-zero blanking: bcd_in=16'h0070, blank_lz=1 -> digits 3 and 2 seg=7'h7F, digit 1 = '7', digit 0 = '0'; same input with blank_lz=0 -> digits 3 and 2 show '0'.
- Double buffer: update 16'h1111, then update 16'h2222 while index=2 -> 1111 is never shown; 2222 appears at the next index-0 slot. Update coincident with frame_done -> the new value appears one frame later.
- Enable and reset: enable=0 at index 2 -> an=1111 and counter frozen for 20 cycles; re-enable resumes at index 2. resetn pulsed low mid-slot -> outputs inactive asynchronously and the active register reads 0.
- Brightness (macro defined): brightness=0, REFRESH_DIV=10, DEAD_CYC=2 -> anode on for 2 cycles per slot; brightness=3 -> 8 cycles.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Purpose: scans a double-buffered 4-digit BCD word onto a multiplexed 7-segment display.
// Latency: seg/an are registered, one cycle behind the refresh counter/digit index; frame_done is same-cycle.
// Backpressure: none; update is always accepted, the newest pending value wins at the next frame boundary.
// Optional feature: define SEG7_SCAN_BRIGHTNESS_EN to truncate the anode on-window by the brightness input.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYC    = 8,
    parameter bit ACTIVE_LOW  = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic [15:0] bcd_in,
    input  logic        update,
    input  logic        blank_lz,
    input  logic [1:0]  brightness,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYC);
    localparam int WIN_FULL = REFRESH_DIV - DEAD_CYC;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [15:0]      act_q, act_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;

    logic             boundary;
    logic             in_window;
    logic [3:0]       digit;
    logic             lz_blank;

    // Segment patterns, active-high {g,f,e,d,c,b,a}; codes C..F render blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'h0:    seg_decode = 7'h3F;
            4'h1:    seg_decode = 7'h06;
            4'h2:    seg_decode = 7'h5B;
            4'h3:    seg_decode = 7'h4F;
            4'h4:    seg_decode = 7'h66;
            4'h5:    seg_decode = 7'h6D;
            4'h6:    seg_decode = 7'h7D;
            4'h7:    seg_decode = 7'h07;
            4'h8:    seg_decode = 7'h7F;
            4'h9:    seg_decode = 7'h6F;
            4'hA:    seg_decode = 7'h40;
            4'hB:    seg_decode = 7'h79;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    // Refresh counter and digit index advance only while scanning is enabled.
    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        boundary = 1'b0;
        if (enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d    = '0;
                idx_d    = idx_q + 2'd1;
                boundary = (idx_q == 2'd3);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Double buffer: capture into pending at any time, promote to active only at a frame boundary.
    // An update on the boundary edge lands after the copy, so it shows one frame later.
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        act_d      = act_q;
        if (boundary && pend_vld_q) begin
            act_d      = pend_q;
            pend_vld_d = 1'b0;
        end
        if (update) begin
            pend_d     = bcd_in;
            pend_vld_d = 1'b1;
        end
    end

`ifdef SEG7_SCAN_BRIGHTNESS_EN
    logic [CNT_W:0] win_len;
    logic [CNT_W:0] win_end;

    // Anode window after dead time shrinks to (brightness+1)/4 of the remainder, at least one cycle.
    always_comb begin
        win_len = (CNT_W+1)'(((int'(brightness) + 1) * WIN_FULL) / 4);
        if (win_len == '0) begin
            win_len = (CNT_W+1)'(1);
        end
        win_end   = (CNT_W+1)'(DEAD_CYC) + win_len;
        in_window = (cnt_q >= CNT_DEAD) && ({1'b0, cnt_q} < win_end);
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;

    // Anode window is the whole slot after the dead time.
    always_comb begin
        in_window = (cnt_q >= CNT_DEAD);
    end
`endif

    // Digit select, leading-zero blanking and next-cycle segment/anode values (active-high).
    always_comb begin
        digit = act_q[{idx_q, 2'b00} +: 4];
        case (idx_q)
            2'd3:    lz_blank = (act_q[15:12] == 4'h0);
            2'd2:    lz_blank = (act_q[15:8] == 8'h00);
            2'd1:    lz_blank = (act_q[15:4] == 12'h000);
            default: lz_blank = 1'b0;
        endcase
        lz_blank = lz_blank && blank_lz;
        seg_d    = (enable && !lz_blank) ? seg_decode(digit) : 7'h00;
        an_d     = (enable && in_window) ? (4'b0001 << idx_q) : 4'b0000;
    end

    // State and output registers; reset leaves everything dark and empty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            pend_q     <= 16'h0000;
            pend_vld_q <= 1'b0;
            act_q      <= 16'h0000;
            seg_q      <= 7'h00;
            an_q       <= 4'h0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            act_q      <= act_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    // Polarity is applied only at the pins.
    assign seg        = ACTIVE_LOW ? ~seg_q : seg_q;
    assign an         = ACTIVE_LOW ? ~an_q : an_q;
    assign dp         = ACTIVE_LOW;
    assign frame_done = boundary;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=8, DEAD_CYC=2, ACTIVE_LOW=1.
// Outputs sampled on the falling edge; inputs driven on the falling edge.
// Expected patterns are the active-low segment encodings written out by hand.
module tb_seg7_scan_driver;

    localparam int DIV  = 8;
    localparam int DEAD = 2;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00, S9 = 7'h10;
    localparam logic [6:0] SDASH = 7'h3F, SE = 7'h06, SOFF = 7'h7F;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [15:0] bcd_in;
    logic        update;
    logic        blank_lz;
    logic [1:0]  brightness;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .REFRESH_DIV(DIV),
        .DEAD_CYC   (DEAD),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .bcd_in    (bcd_in),
        .update    (update),
        .blank_lz  (blank_lz),
        .brightness(brightness),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .frame_done(frame_done)
    );

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_frame: frame_done=%b after 200 cycles, required 1", frame_done);
        end
    endtask

    task automatic load(input logic [15:0] v);
        @(negedge clk);
        bcd_in = v;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    // Captures one full frame of outputs following a boundary and checks every cycle per digit.
    task automatic check_frame(input string name, input logic [3:0][6:0] exp_seg,
                               input int on_cyc, input bit do_wait);
        bit         ok;
        int         bad [4];
        logic [3:0] got_an [4];
        logic [6:0] got_seg [4];
        logic [3:0] want_an [4];
        logic [3:0] exp_an;
        int         k;
        int         c;
        ok = 1'b1;
        if (do_wait) wait_frame(ok);
        if (ok) begin
            @(posedge clk);
            #1 update = 1'b0;
            for (int j = 0; j < 4; j++) begin
                bad[j] = 0;
                got_an[j] = 4'h0;
                got_seg[j] = 7'h00;
                want_an[j] = 4'h0;
            end
            for (int i = 0; i < 32; i++) begin
                k = i / DIV;
                c = i % DIV;
                @(posedge clk);
                @(negedge clk);
                exp_an = (c >= DEAD && c < DEAD + on_cyc) ? ~(4'b0001 << k) : 4'hF;
                if (an !== exp_an || dp !== 1'b1 || frame_done !== (i == 30) ||
                    (exp_an != 4'hF && seg !== exp_seg[k])) begin
                    if (bad[k] == 0) begin
                        got_an[k]  = an;
                        got_seg[k] = seg;
                        want_an[k] = exp_an;
                    end
                    bad[k]++;
                end
            end
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (bad[j] != 0) begin
                    errors++;
                    $display("FAIL %s digit%0d: %0d bad cycles, first got an=%b seg=%h, required an=%b seg=%h",
                             name, j, bad[j], got_an[j], got_seg[j], want_an[j], exp_seg[j]);
                end
            end
        end
    endtask

    task automatic test_reset;
        int bad;
        resetn     = 1'b0;
        enable     = 1'b1;
        update     = 1'b1;
        bcd_in     = 16'h8888;
        blank_lz   = 1'b0;
        brightness = 2'd3;
        repeat (3) @(negedge clk);
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an: got %b required 1111", an); end
        checks++; if (seg !== SOFF) begin errors++; $display("FAIL reset_seg: got %h required 7f", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b required 1", dp); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b required 0", frame_done); end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an !== 4'hF || seg !== SOFF || frame_done !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL reset_hold: %0d cycles active, required 0", bad); end
        update = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check_frame("after_reset", {S0, S0, S0, S0}, DIV - DEAD, 1'b1);
    endtask

    task automatic test_basic_scan;
        bit ok;
        int n;
        load(16'h1234);
        check_frame("basic", {S1, S2, S3, S4}, DIV - DEAD, 1'b1);
        wait_frame(ok);
        if (ok) begin
            n = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                n++;
                if (frame_done === 1'b1) break;
            end
            checks++; if (n != 32) begin errors++; $display("FAIL frame_period: got %0d cycles required 32", n); end
        end
    endtask

    task automatic test_lz_blanking;
        blank_lz = 1'b1;
        load(16'h0070);
        check_frame("lz_on", {SOFF, SOFF, S7, S0}, DIV - DEAD, 1'b1);
        blank_lz = 1'b0;
        check_frame("lz_off", {S0, S0, S7, S0}, DIV - DEAD, 1'b1);
        blank_lz = 1'b1;
        load(16'h0000);
        check_frame("lz_zero", {SOFF, SOFF, SOFF, S0}, DIV - DEAD, 1'b1);
        load(16'h5680);
        check_frame("lz_msd_set", {S5, S6, S8, S0}, DIV - DEAD, 1'b1);
        blank_lz = 1'b0;
        load(16'hABC9);
        check_frame("decode_abc", {SDASH, SE, SOFF, S9}, DIV - DEAD, 1'b1);
    endtask

    task automatic test_double_buffer;
        bit ok;
        wait_frame(ok);
        load(16'h1111);
        repeat (17) @(negedge clk);
        load(16'h2222);
        check_frame("dbuf_last_wins", {S2, S2, S2, S2}, DIV - DEAD, 1'b1);
        wait_frame(ok);
        bcd_in = 16'h3333;
        update = 1'b1;
        check_frame("coinc_old", {S2, S2, S2, S2}, DIV - DEAD, 1'b0);
        check_frame("coinc_new", {S3, S3, S3, S3}, DIV - DEAD, 1'b1);
    endtask

    task automatic test_enable;
        bit ok;
        int bad;
        int n;
        wait_frame(ok);
        repeat (19) @(negedge clk);
        enable = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an !== 4'hF || seg !== SOFF || frame_done !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL enable_off: %0d cycles active, required 0", bad); end
        enable = 1'b1;
        @(negedge clk);
        checks++; if (an !== 4'b1011) begin errors++; $display("FAIL resume_an: got %b required 1011", an); end
        checks++; if (seg !== S3) begin errors++; $display("FAIL resume_seg: got %h required %h", seg, S3); end
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (frame_done === 1'b1) break;
        end
        checks++; if (n != 12) begin errors++; $display("FAIL resume_to_frame: got %0d cycles required 12", n); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        wait_frame(ok);
        load(16'h9876);
        repeat (2) @(negedge clk);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL pre_reset_an: got %b required 1110", an); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL async_reset_an: got %b required 1111", an); end
        checks++; if (seg !== SOFF) begin errors++; $display("FAIL async_reset_seg: got %h required 7f", seg); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        check_frame("post_mid_reset", {S0, S0, S0, S0}, DIV - DEAD, 1'b1);
    endtask

    task automatic test_brightness;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
        brightness = 2'd0;
        check_frame("bright0", {S0, S0, S0, S0}, 1, 1'b1);
        brightness = 2'd1;
        check_frame("bright1", {S0, S0, S0, S0}, 3, 1'b1);
        brightness = 2'd3;
        check_frame("bright3", {S0, S0, S0, S0}, 6, 1'b1);
`else
        brightness = 2'd0;
        check_frame("bright_ignored", {S0, S0, S0, S0}, DIV - DEAD, 1'b1);
        brightness = 2'd3;
`endif
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_lz_blanking();
        test_double_buffer();
        test_enable();
        test_reset_mid();
        test_brightness();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
